// File: rtl/sr_bank_driver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sr_bank_driver_pkg : shared types and constants for the SR bank driver     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package sr_bank_driver_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    // Counter holds (cycles - 1), so it needs to represent max(a,b)-1 (at least 1 bit).
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_bank_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sr_bank_driver_if : target handshake and SR bank strobe/feedback bundle    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface sr_bank_driver_if #(
    parameter int WIDTH = 8
);
    logic             tgt_valid;
    logic [WIDTH-1:0] tgt_data;
    logic             tgt_ready;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] s_out;
    logic [WIDTH-1:0] r_out;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] mismatch;

    modport master (
        output tgt_valid, tgt_data, q_fb,
        input  tgt_ready, s_out, r_out, busy, done, err, mismatch
    );

    modport slave (
        input  tgt_valid, tgt_data, q_fb,
        output tgt_ready, s_out, r_out, busy, done, err, mismatch
    );
endinterface
`default_nettype wire

// File: rtl/sr_bank_driver_cyc_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cyc_down_counter : loadable down counter with zero flag for state timing   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module cyc_down_counter #(
    parameter int W = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         load_i,
    input  wire logic [W-1:0] value_i,
    output logic              zero_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule
`default_nettype wire

// File: rtl/sr_bank_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sr_bank_driver : writes a target word into a clocked SR flop bank with     |
// |                  set/reset strobes, read-back check and bounded retry      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module sr_bank_driver
    import sr_bank_driver_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PULSE_CYC  = 1,
    parameter int SETTLE_CYC = 2,
    parameter int MAX_RETRY  = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    sr_bank_driver_if.slave   bus
);
    localparam int CNT_W = cnt_width(PULSE_CYC, SETTLE_CYC);
    localparam logic [CNT_W-1:0]   C_PULSE_LD  = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]   C_SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [RETRY_W-1:0] C_MAX_RETRY = RETRY_W'(MAX_RETRY);

    state_t             state_q;
    logic [WIDTH-1:0]   tgt_q;
    logic [WIDTH-1:0]   s_q;
    logic [WIDTH-1:0]   r_q;
    logic [RETRY_W-1:0] retry_q;
    logic               done_q;
    logic               err_q;
    logic [WIDTH-1:0]   mismatch_q;

    logic               accept;
    logic [WIDTH-1:0]   acc_set;
    logic [WIDTH-1:0]   acc_clr;
    logic [WIDTH-1:0]   mm;
    logic [WIDTH-1:0]   chk_set;
    logic [WIDTH-1:0]   chk_clr;
    logic               retry_ok;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_zero;

    always_comb begin
        accept   = bus.tgt_valid && (state_q == ST_IDLE);
        acc_set  = bus.tgt_data & ~bus.q_fb;
        acc_clr  = ~bus.tgt_data & bus.q_fb;
        mm       = bus.q_fb ^ tgt_q;
        chk_set  = tgt_q & ~bus.q_fb;
        chk_clr  = ~tgt_q & bus.q_fb;
        retry_ok = (mm != '0) && (retry_q < C_MAX_RETRY);
        cnt_load = 1'b0;
        cnt_val  = '0;
        // The counter is reloaded on the same edge that enters PULSE or SETTLE.
        case (state_q)
            ST_IDLE: begin
                if (accept && ((acc_set | acc_clr) != '0)) begin
                    cnt_load = 1'b1;
                    cnt_val  = C_PULSE_LD;
                end
            end
            ST_PULSE: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = C_SETTLE_LD;
                end
            end
            ST_CHECK: begin
                if (retry_ok) begin
                    cnt_load = 1'b1;
                    cnt_val  = C_PULSE_LD;
                end
            end
            default: ;
        endcase
    end

    cyc_down_counter #(
        .W       (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (cnt_load),
        .value_i (cnt_val),
        .zero_o  (cnt_zero)
    );

    // s_q/r_q hold the set/clear masks for the whole pulse and drive the bank directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tgt_q      <= '0;
            s_q        <= '0;
            r_q        <= '0;
            retry_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mismatch_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        tgt_q      <= bus.tgt_data;
                        retry_q    <= '0;
                        err_q      <= 1'b0;
                        mismatch_q <= '0;
                        if ((acc_set | acc_clr) != '0) begin
                            s_q     <= acc_set;
                            r_q     <= acc_clr;
                            state_q <= ST_PULSE;
                        end else begin
                            state_q <= ST_CHECK;
                        end
                    end
                end
                ST_PULSE: begin
                    if (cnt_zero) begin
                        s_q     <= '0;
                        r_q     <= '0;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_zero) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (retry_ok) begin
                        s_q     <= chk_set;
                        r_q     <= chk_clr;
                        retry_q <= retry_q + RETRY_W'(1);
                        state_q <= ST_PULSE;
                    end else begin
                        done_q     <= 1'b1;
                        err_q      <= (mm != '0);
                        mismatch_q <= mm;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.tgt_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.s_out     = s_q;
    assign bus.r_out     = r_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mismatch  = mismatch_q;
endmodule
`default_nettype wire

// File: tb/tb_sr_bank_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sr_bank_driver : directed bench with an SR bank model (set priority)    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_sr_bank_driver;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   overlap_cnt;

    logic [7:0] bank_q;
    logic [7:0] preload_val;
    logic [7:0] stuck0;
    logic       preload_en;

    sr_bank_driver_if #(.WIDTH(8)) bus ();

    sr_bank_driver #(
        .WIDTH      (8),
        .PULSE_CYC  (1),
        .SETTLE_CYC (2),
        .MAX_RETRY  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank of clocked SR flops; set wins over reset, stuck0 bits can never rise.
    always @(posedge clk) begin
        if (preload_en)
            bank_q <= preload_val & ~stuck0;
        else
            bank_q <= (bus.s_out | (bank_q & ~bus.r_out)) & ~stuck0;
    end
    assign bus.q_fb = bank_q;

    always @(negedge clk) begin
        if ((bus.s_out & bus.r_out) != 8'h00)
            overlap_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_bank(input logic [7:0] v);
        preload_en  = 1'b1;
        preload_val = v;
        cyc(1);
        preload_en  = 1'b0;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        overlap_cnt   = 0;
        rst_n         = 1'b0;
        bus.tgt_valid = 1'b0;
        bus.tgt_data  = 8'h00;
        preload_en    = 1'b1;
        preload_val   = 8'h00;
        stuck0        = 8'h00;
        cyc(2);
        chk("rst_s_out", bus.s_out, 8'h00);
        chk("rst_r_out", bus.r_out, 8'h00);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_mismatch", bus.mismatch, 8'h00);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", bus.tgt_ready, 1'b1);
        cyc(1);

        // Basic write: 00 -> A5
        load_bank(8'h00);
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 8'hA5;
        cyc(1);
        bus.tgt_valid = 1'b0;
        chk("basic_s", bus.s_out, 8'hA5);
        chk("basic_r", bus.r_out, 8'h00);
        chk("basic_busy", bus.busy, 1'b1);
        chk("basic_ready", bus.tgt_ready, 1'b0);
        cyc(1);
        chk("basic_s_off", bus.s_out, 8'h00);
        cyc(2);
        chk("basic_done_early", bus.done, 1'b0);
        cyc(1);
        chk("basic_done", bus.done, 1'b1);
        chk("basic_err", bus.err, 1'b0);
        chk("basic_mm", bus.mismatch, 8'h00);
        chk("basic_ready_done", bus.tgt_ready, 1'b1);
        chk("basic_bank", bank_q, 8'hA5);
        cyc(1);
        chk("basic_done_pulse", bus.done, 1'b0);

        // Mixed write: F0 -> 3C
        load_bank(8'hF0);
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 8'h3C;
        cyc(1);
        bus.tgt_valid = 1'b0;
        chk("mixed_s", bus.s_out, 8'h0C);
        chk("mixed_r", bus.r_out, 8'hC0);
        cyc(4);
        chk("mixed_done", bus.done, 1'b1);
        chk("mixed_err", bus.err, 1'b0);
        chk("mixed_bank", bank_q, 8'h3C);
        cyc(1);

        // No-op: 5A -> 5A
        load_bank(8'h5A);
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 8'h5A;
        cyc(1);
        bus.tgt_valid = 1'b0;
        chk("noop_s", bus.s_out, 8'h00);
        chk("noop_r", bus.r_out, 8'h00);
        chk("noop_busy", bus.busy, 1'b1);
        chk("noop_done_early", bus.done, 1'b0);
        cyc(1);
        chk("noop_done", bus.done, 1'b1);
        chk("noop_err", bus.err, 1'b0);
        chk("noop_mm", bus.mismatch, 8'h00);
        cyc(1);

        // Retry/fail: bit 0 stuck low, target 01
        stuck0 = 8'h01;
        load_bank(8'h00);
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 8'h01;
        cyc(1);
        bus.tgt_valid = 1'b0;
        chk("retry_s1", bus.s_out, 8'h01);
        cyc(4);
        chk("retry_s2", bus.s_out, 8'h01);
        chk("retry_done_mid", bus.done, 1'b0);
        cyc(4);
        chk("retry_done", bus.done, 1'b1);
        chk("retry_err", bus.err, 1'b1);
        chk("retry_mm", bus.mismatch, 8'h01);
        cyc(1);
        chk("retry_done_pulse", bus.done, 1'b0);
        chk("retry_err_held", bus.err, 1'b1);
        chk("retry_mm_held", bus.mismatch, 8'h01);

        // Handshake: valid held with new data during busy, back-to-back on done
        stuck0        = 8'h00;
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 8'h0F;
        cyc(1);
        bus.tgt_data  = 8'hF0;
        chk("hs_err_cleared", bus.err, 1'b0);
        chk("hs_mm_cleared", bus.mismatch, 8'h00);
        chk("hs_s1", bus.s_out, 8'h0F);
        cyc(3);
        chk("hs_no_accept_busy", bus.s_out, 8'h00);
        chk("hs_done_early", bus.done, 1'b0);
        cyc(1);
        chk("hs_done1", bus.done, 1'b1);
        chk("hs_bank1", bank_q, 8'h0F);
        chk("hs_ready_done", bus.tgt_ready, 1'b1);
        cyc(1);
        bus.tgt_valid = 1'b0;
        chk("hs_b2b_s", bus.s_out, 8'hF0);
        chk("hs_b2b_r", bus.r_out, 8'h0F);
        chk("hs_b2b_busy", bus.busy, 1'b1);
        cyc(4);
        chk("hs_done2", bus.done, 1'b1);
        chk("hs_bank2", bank_q, 8'hF0);
        cyc(1);

        // Reset asserted mid-PULSE
        load_bank(8'h00);
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 8'hFF;
        cyc(1);
        bus.tgt_valid = 1'b0;
        chk("arst_pre_s", bus.s_out, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_s", bus.s_out, 8'h00);
        chk("arst_r", bus.r_out, 8'h00);
        chk("arst_busy", bus.busy, 1'b0);
        cyc(1);
        rst_n = 1'b1;
        #1;
        chk("arst_ready", bus.tgt_ready, 1'b1);
        chk("arst_done", bus.done, 1'b0);
        cyc(2);
        chk("arst_done_after", bus.done, 1'b0);
        chk("arst_idle_s", bus.s_out, 8'h00);

        chk("no_overlap", overlap_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
